dma2mem_txn_capture: RTL and testbench
======================================

Name: dma2mem_txn_capture

Overview:
- Parametrised multi-lane capture block for DMA-to-memory-controller traffic inside a PE.
- Replaces the bench's per-lane, stream-0-only assign probes with a synthesizable recorder.
- Per lane: counts write, read-request and read-data events; tracks outstanding reads; queues one selected event class per cycle in a per-lane FIFO.
- A round-robin arbiter drains all lane FIFOs onto a single valid/ready capture stream for the bench or an upstream debug port.

Parameters:
- NUM_LANES, 4, number of observed DMA lanes (1..32).
- ADDR_WIDTH, 24, DMA address width.
- DATA_WIDTH, 32, DMA data width.
- FIFO_DEPTH, 8, entries per lane FIFO (power of two, >=2).
- CNT_WIDTH, 16, width of every event counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_poweron  in  1  asynchronous, active-low reset.
- enable  in  1  capture/count enable; when 0 no counts and no FIFO pushes.
- clear  in  1  synchronous clear of counters, flags and FIFOs.
- capture_mode  in  2  event class queued: 0 write, 1 read request, 2 read data, 3 none.
- dma__memc__write_valid  in  NUM_LANES  per-lane write valid.
- dma__memc__write_address  in  NUM_LANES*ADDR_WIDTH  packed, lane 0 in LSBs.
- dma__memc__write_data  in  NUM_LANES*DATA_WIDTH  packed.
- memc__dma__write_ready  in  NUM_LANES  per-lane write ready.
- dma__memc__read_valid  in  NUM_LANES  read request valid.
- dma__memc__read_address  in  NUM_LANES*ADDR_WIDTH  packed.
- dma__memc__read_pause  in  NUM_LANES  read pause.
- memc__dma__read_ready  in  NUM_LANES  read request ready.
- memc__dma__read_data_valid  in  NUM_LANES  read data valid.
- memc__dma__read_data  in  NUM_LANES*DATA_WIDTH  packed.
- cap__out_valid  out  1  capture entry valid.
- cap__out_ready  in  1  downstream accept.
- cap__out_lane  out  $clog2(NUM_LANES) max 1  source lane.
- cap__out_type  out  2  event class, same encoding as capture_mode.
- cap__out_address  out  ADDR_WIDTH  address; 0 for read-data entries.
- cap__out_data  out  DATA_WIDTH  data; 0 for read-request entries.
- write_count  out  NUM_LANES*CNT_WIDTH  accepted writes per lane.
- read_count  out  NUM_LANES*CNT_WIDTH  accepted read requests per lane.
- outstanding  out  NUM_LANES*CNT_WIDTH  read requests minus read data returns.
- overflow  out  NUM_LANES  sticky: push dropped because FIFO full.
- underflow  out  NUM_LANES  sticky: read data received with outstanding==0.

Behaviour:
- Reset (async assert, sync deassert internally): all counters, flags, FIFO pointers, arbiter pointer (lane 0) and every cap__out_* signal are 0.

Event definitions per lane, sampled each rising edge with enable=1:
- W: write_valid & write_ready.
- R: read_valid & read_ready & !read_pause.
- D: read_data_valid.
- W, R and D are independent; all three may occur in one cycle, and all are counted.

Counters:
- write_count and read_count saturate at all-ones.
- outstanding: +1 on R, -1 on D, unchanged on R&D in the same cycle.
- D with outstanding==0 and no R that cycle sets underflow and leaves outstanding at 0.
- outstanding saturates high.

FIFO push:
- Only the event selected by capture_mode is pushed, at most one per lane per cycle.
- Push is on the same edge the event is sampled.
- Full FIFO: the entry is dropped and overflow is set, even if the same lane is popped that cycle.

Arbiter / output:
- Output register loads when (!cap__out_valid | cap__out_ready) and at least one FIFO is non-empty.
- Grant is round-robin starting at (last granted lane + 1) mod NUM_LANES.
- The granted FIFO pops on the same edge.
- Entry fields and cap__out_* stay stable while valid & !ready.
- Latency: event on edge N gives earliest cap__out_valid after edge N+1.
- Sustained throughput is one entry per cycle.

clear:
- Takes precedence over all events that cycle and empties every FIFO.
- Drops cap__out_valid to 0 and resets the arbiter pointer to lane 0.

Other:
- capture_mode change takes effect on the next edge; entries already queued keep their type.
- enable=0 does not stop draining of the FIFOs.

Test Plan:
- Reset released, lane 2 performs 3 W (addr 0x10/0x11/0x12, data 1/2/3) with mode 0 and out_ready=1 -> three entries lane=2 type=0 in order; write_count[2]=3; first valid one cycle after the first W edge.
- Lanes 0,1,3 each push one W in the same cycle -> output order lane 0,1,3; the next simultaneous burst starts at lane 0 again after pointer wrap.
- Mode 0, out_ready=0, lane 0 issues 10 W with FIFO_DEPTH=8 -> 8 queued plus 1 held in the output register, 1 dropped; overflow[0]=1; write_count[0]=10.
- Lane 1: 4 R, then R&D in the same cycle, then 4 D, then 1 extra D -> outstanding 4,4,0 after the 4 D; after the extra D underflow[1]=1 and outstanding stays 0.
- R with read_pause=1 -> not counted; R with pause=0 and mode 1 -> entry type=1 carrying the address and data 0.
- Assert clear mid-stream with a full FIFO and out_valid=1 -> next cycle counters=0, flags=0, out_valid=0; async reset mid-burst gives the same all-zero state immediately.

Source files
------------

// File: rtl/dma2mem_txn_capture.sv
// dma2mem_txn_capture: per-lane DMA/memc event counters and FIFOs drained round-robin onto one capture stream
module dma2mem_txn_capture #(
    parameter int NUM_LANES  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [1:0]                      capture_mode,
    input  logic [NUM_LANES-1:0]            dma__memc__write_valid,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] dma__memc__write_address,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] dma__memc__write_data,
    input  logic [NUM_LANES-1:0]            memc__dma__write_ready,
    input  logic [NUM_LANES-1:0]            dma__memc__read_valid,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] dma__memc__read_address,
    input  logic [NUM_LANES-1:0]            dma__memc__read_pause,
    input  logic [NUM_LANES-1:0]            memc__dma__read_ready,
    input  logic [NUM_LANES-1:0]            memc__dma__read_data_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] memc__dma__read_data,
    output logic                            cap__out_valid,
    input  logic                            cap__out_ready,
    output logic [LW-1:0]                   cap__out_lane,
    output logic [1:0]                      cap__out_type,
    output logic [ADDR_WIDTH-1:0]           cap__out_address,
    output logic [DATA_WIDTH-1:0]           cap__out_data,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  write_count,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  read_count,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  outstanding,
    output logic [NUM_LANES-1:0]            overflow,
    output logic [NUM_LANES-1:0]            underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 + ADDR_WIDTH + DATA_WIDTH;

    logic [1:0]           rst_sync;
    logic                 rst_n;
    logic [NUM_LANES-1:0] nonempty;
    logic [NUM_LANES-1:0] pop;
    logic [EW-1:0]        head [NUM_LANES];
    logic [LW-1:0]        ptr;
    logic [LW-1:0]        gnt;
    logic                 found;
    logic                 load;

    always_ff @(posedge clk or negedge reset_poweron)
        if (!reset_poweron) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic                  w, r, d, sel, full, of, uf;
        logic [CNT_WIDTH-1:0]  wc, rc, oc;
        logic [AW:0]           wr_ptr, rd_ptr;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] ed;
        logic [EW-1:0]         entry;
        logic [EW-1:0]         mem [FIFO_DEPTH];
        assign w = enable & dma__memc__write_valid[l] & memc__dma__write_ready[l];
        assign r = enable & dma__memc__read_valid[l] & memc__dma__read_ready[l] & ~dma__memc__read_pause[l];
        assign d = enable & memc__dma__read_data_valid[l];
        assign sel = capture_mode == 2'd0 ? w : capture_mode == 2'd1 ? r : capture_mode == 2'd2 ? d : 1'b0;
        assign ea = capture_mode == 2'd0 ? dma__memc__write_address[l*ADDR_WIDTH +: ADDR_WIDTH] :
                    capture_mode == 2'd1 ? dma__memc__read_address[l*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        assign ed = capture_mode == 2'd0 ? dma__memc__write_data[l*DATA_WIDTH +: DATA_WIDTH] :
                    capture_mode == 2'd2 ? memc__dma__read_data[l*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign entry = {capture_mode, ea, ed};
        assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign nonempty[l] = wr_ptr != rd_ptr;
        assign head[l] = mem[rd_ptr[AW-1:0]];
        assign write_count[l*CNT_WIDTH +: CNT_WIDTH] = wc;
        assign read_count[l*CNT_WIDTH +: CNT_WIDTH] = rc;
        assign outstanding[l*CNT_WIDTH +: CNT_WIDTH] = oc;
        assign overflow[l] = of;
        assign underflow[l] = uf;
        always_ff @(posedge clk)
            if (sel && !full && !clear) mem[wr_ptr[AW-1:0]] <= entry;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                wc <= '0;
                rc <= '0;
                oc <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                of <= 1'b0;
                uf <= 1'b0;
            end else if (clear) begin
                wc <= '0;
                rc <= '0;
                oc <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                of <= 1'b0;
                uf <= 1'b0;
            end else begin
                if (w && wc != '1) wc <= wc + 1'b1;
                if (r && rc != '1) rc <= rc + 1'b1;
                if (r && !d && oc != '1) oc <= oc + 1'b1;
                else if (d && !r) begin
                    if (oc == '0) uf <= 1'b1;
                    else oc <= oc - 1'b1;
                end
                // a full FIFO drops the push even when it is popped on this edge
                if (sel) begin
                    if (full) of <= 1'b1;
                    else wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[l]) rd_ptr <= rd_ptr + 1'b1;
            end
    end

    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && nonempty[(int'(ptr) + i) % NUM_LANES]) begin
                found = 1'b1;
                gnt = LW'((int'(ptr) + i) % NUM_LANES);
            end
        end
    end

    assign load = (!cap__out_valid || cap__out_ready) && found;
    assign pop = load ? (NUM_LANES'(1) << gnt) : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cap__out_valid <= 1'b0;
            cap__out_lane <= '0;
            cap__out_type <= '0;
            cap__out_address <= '0;
            cap__out_data <= '0;
            ptr <= '0;
        end else if (clear) begin
            cap__out_valid <= 1'b0;
            cap__out_lane <= '0;
            cap__out_type <= '0;
            cap__out_address <= '0;
            cap__out_data <= '0;
            ptr <= '0;
        end else if (load) begin
            cap__out_valid <= 1'b1;
            cap__out_lane <= gnt;
            {cap__out_type, cap__out_address, cap__out_data} <= head[gnt];
            ptr <= gnt == LW'(NUM_LANES - 1) ? '0 : gnt + 1'b1;
        end else if (cap__out_ready) begin
            cap__out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_dma2mem_txn_capture.sv
// tb_dma2mem_txn_capture: directed plus random stimulus against a queue-based reference model
module tb_dma2mem_txn_capture;
    localparam int N = 4;
    localparam int AWD = 24;
    localparam int DWD = 32;
    localparam int DEPTH = 8;
    localparam int CW = 16;
    localparam int EW = 2 + AWD + DWD;

    logic             clk = 1'b0;
    logic             reset_poweron = 1'b0;
    logic             enable = 1'b1;
    logic             clear = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [N-1:0]     wv = '0, wr = '0, rv = '0, rpause = '0, rr = '0, dv = '0;
    logic [N*AWD-1:0] waddr = '0, raddr = '0;
    logic [N*DWD-1:0] wdata = '0, rdata = '0;
    logic             rdy = 1'b1;
    logic             cap_valid;
    logic [1:0]       cap_lane;
    logic [1:0]       cap_type;
    logic [AWD-1:0]   cap_addr;
    logic [DWD-1:0]   cap_data;
    logic [N*CW-1:0]  write_count, read_count, outstanding;
    logic [N-1:0]     overflow, underflow;

    int n_tests = 0;
    int n_fail = 0;

    logic [15:0]   mw [N];
    logic [15:0]   mr [N];
    logic [15:0]   mo [N];
    bit            mof [N];
    bit            muf [N];
    logic [EW-1:0] q [N][$];
    bit            m_valid;
    logic [1:0]    m_lane;
    logic [EW-1:0] m_ent;
    int            m_ptr;

    dma2mem_txn_capture #(.NUM_LANES(N), .ADDR_WIDTH(AWD), .DATA_WIDTH(DWD), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset_poweron(reset_poweron),
        .enable(enable),
        .clear(clear),
        .capture_mode(mode),
        .dma__memc__write_valid(wv),
        .dma__memc__write_address(waddr),
        .dma__memc__write_data(wdata),
        .memc__dma__write_ready(wr),
        .dma__memc__read_valid(rv),
        .dma__memc__read_address(raddr),
        .dma__memc__read_pause(rpause),
        .memc__dma__read_ready(rr),
        .memc__dma__read_data_valid(dv),
        .memc__dma__read_data(rdata),
        .cap__out_valid(cap_valid),
        .cap__out_ready(rdy),
        .cap__out_lane(cap_lane),
        .cap__out_type(cap_type),
        .cap__out_address(cap_addr),
        .cap__out_data(cap_data),
        .write_count(write_count),
        .read_count(read_count),
        .outstanding(outstanding),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < N; l++) begin
            mw[l] = '0;
            mr[l] = '0;
            mo[l] = '0;
            mof[l] = 0;
            muf[l] = 0;
            q[l].delete();
        end
        m_valid = 0;
        m_lane = '0;
        m_ent = '0;
        m_ptr = 0;
    endtask

    task automatic model_step();
        bit full [N];
        bit f;
        logic [1:0] g;
        if (clear) begin
            model_reset();
            return;
        end
        for (int l = 0; l < N; l++) full[l] = q[l].size() >= DEPTH;
        if (!m_valid || rdy) begin
            f = 0;
            g = '0;
            for (int i = 0; i < N; i++) begin
                int l = (m_ptr + i) % N;
                if (!f && q[l].size() > 0) begin
                    f = 1;
                    g = 2'(l);
                end
            end
            if (f) begin
                m_ent = q[g].pop_front();
                m_lane = g;
                m_valid = 1;
                m_ptr = (int'(g) + 1) % N;
            end else m_valid = 0;
        end
        if (enable) begin
            for (int l = 0; l < N; l++) begin
                bit w, r, d, s;
                w = wv[l] & wr[l];
                r = rv[l] & rr[l] & ~rpause[l];
                d = dv[l];
                if (w && mw[l] != 16'hFFFF) mw[l]++;
                if (r && mr[l] != 16'hFFFF) mr[l]++;
                if (r && !d) begin
                    if (mo[l] != 16'hFFFF) mo[l]++;
                end else if (d && !r) begin
                    if (mo[l] == 0) muf[l] = 1;
                    else mo[l]--;
                end
                s = mode == 0 ? w : mode == 1 ? r : mode == 2 ? d : 0;
                if (s) begin
                    if (full[l]) mof[l] = 1;
                    else q[l].push_back({mode,
                        mode == 0 ? waddr[l*AWD +: AWD] : mode == 1 ? raddr[l*AWD +: AWD] : 24'h0,
                        mode == 0 ? wdata[l*DWD +: DWD] : mode == 2 ? rdata[l*DWD +: DWD] : 32'h0});
                end
            end
        end
    endtask

    task automatic compare();
        logic [N*CW-1:0] ew, er, eo;
        logic [N-1:0] eof, euf;
        for (int l = 0; l < N; l++) begin
            ew[l*CW +: CW] = mw[l];
            er[l*CW +: CW] = mr[l];
            eo[l*CW +: CW] = mo[l];
            eof[l] = mof[l];
            euf[l] = muf[l];
        end
        chk("out_valid", cap_valid, m_valid);
        if (m_valid) chk("out_entry", {cap_lane, cap_type, cap_addr, cap_data}, {m_lane, m_ent});
        chk("write_count", write_count, ew);
        chk("read_count", read_count, er);
        chk("outstanding", outstanding, eo);
        chk("flags", {overflow, underflow}, {eof, euf});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        wv = '0; wr = '0; rv = '0; rr = '0; rpause = '0; dv = '0; clear = 1'b0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_valid", cap_valid, 0);
        chk("rst_fields", {cap_lane, cap_type, cap_addr, cap_data}, 0);
        chk("rst_counts", {write_count, read_count, outstanding}, 0);
        chk("rst_flags", {overflow, underflow}, 0);
        repeat (2) @(posedge clk);
        #1 reset_poweron = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // lane 2 writes three entries; first valid one edge after the first write
        mode = 2'd0; rdy = 1'b1;
        wv[2] = 1'b1; wr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            waddr[2*AWD +: AWD] = 24'h10 + 24'(i);
            wdata[2*DWD +: DWD] = 32'(i + 1);
            step();
            if (i == 0) chk("latency_early", cap_valid, 0);
            if (i == 1) chk("latency_first", {cap_valid, cap_lane, cap_addr}, {1'b1, 2'd2, 24'h10});
        end
        idle();
        repeat (3) step();
        chk("wcount_lane2", write_count[2*CW +: CW], 3);

        // simultaneous writes on lanes 0,1,3 drain in round-robin order
        do_clear();
        wv = 4'b1011; wr = 4'b1011;
        step();
        idle();
        step(); chk("rr_first", cap_lane, 0);
        step(); chk("rr_second", cap_lane, 1);
        step(); chk("rr_third", cap_lane, 3);
        step();
        wv = 4'b1011; wr = 4'b1011;
        step();
        idle();
        step(); chk("rr_wrap", {cap_valid, cap_lane}, {1'b1, 2'd0});
        repeat (3) step();

        // overflow with the output stalled, then clear mid-stream
        do_clear();
        rdy = 1'b0;
        wv[0] = 1'b1; wr[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            waddr[0 +: AWD] = 24'h100 + 24'(i);
            wdata[0 +: DWD] = 32'hA0 + 32'(i);
            step();
        end
        idle();
        step();
        chk("ovf_flag", overflow[0], 1);
        chk("ovf_wcount", write_count[0 +: CW], 10);
        chk("ovf_held", {cap_valid, cap_addr}, {1'b1, 24'h100});
        do_clear();
        chk("clr_valid", cap_valid, 0);
        chk("clr_counts", {write_count, read_count, outstanding}, 0);
        chk("clr_flags", {overflow, underflow}, 0);
        rdy = 1'b1;

        // outstanding tracking and underflow on lane 1
        mode = 2'd2;
        rv[1] = 1'b1; rr[1] = 1'b1;
        repeat (4) step();
        chk("outst_4", outstanding[CW +: CW], 4);
        dv[1] = 1'b1;
        rdata[DWD +: DWD] = 32'h5A5A;
        step();
        chk("outst_rd", outstanding[CW +: CW], 4);
        rv[1] = 1'b0; rr[1] = 1'b0;
        repeat (4) step();
        chk("outst_0", {outstanding[CW +: CW], underflow[1]}, 0);
        step();
        chk("underflow", {outstanding[CW +: CW], underflow[1]}, 1);
        idle();
        repeat (8) step();

        // paused read requests are ignored; unpaused one is queued as type 1
        mode = 2'd1;
        rv[3] = 1'b1; rr[3] = 1'b1; rpause[3] = 1'b1;
        raddr[3*AWD +: AWD] = 24'hABCDE;
        step();
        chk("pause_rcount", read_count[3*CW +: CW], 0);
        rpause[3] = 1'b0;
        step();
        idle();
        step();
        chk("rreq_entry", {cap_valid, cap_lane, cap_type, cap_addr, cap_data}, {1'b1, 2'd3, 2'd1, 24'hABCDE, 32'h0});
        chk("rreq_count", read_count[3*CW +: CW], 1);
        repeat (3) step();

        // async reset mid-burst
        mode = 2'd0; rdy = 1'b0;
        wv = 4'hF; wr = 4'hF;
        repeat (3) step();
        #3 reset_poweron = 1'b0;
        #1;
        chk("arst_valid", cap_valid, 0);
        chk("arst_counts", {write_count, read_count, outstanding}, 0);
        chk("arst_flags", {overflow, underflow}, 0);
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_poweron = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = 2'($urandom_range(0, 3));
            enable = ($urandom % 8) != 0;
            clear = ($urandom % 200) == 0;
            rdy = ($urandom % 4) != 0;
            wv = 4'($urandom); wr = 4'($urandom);
            rv = 4'($urandom); rr = 4'($urandom); rpause = 4'($urandom);
            dv = 4'($urandom) & 4'($urandom);
            for (int l = 0; l < N; l++) begin
                waddr[l*AWD +: AWD] = 24'($urandom);
                raddr[l*AWD +: AWD] = 24'($urandom);
                wdata[l*DWD +: DWD] = $urandom;
                rdata[l*DWD +: DWD] = $urandom;
            end
            step();
        end
        idle();
        enable = 1'b1;
        rdy = 1'b1;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
